// File: rtl/locker_ctrl.sv
// locker_ctrl: registered sequencing controller for the keypad combination lock.
// Takes one digit per digit_valid strobe, tracks progress through a 5-digit code,
// counts failed attempts, enforces a timed lockout, and holds the lock open for a
// bounded time before relocking.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   digit        keypad digit, sampled only when digit_valid=1
//   digit_valid  one-cycle strobe: digit is valid this cycle
//   relock       request immediate relock while OPEN
//   ready        1 = a digit_valid this cycle will be consumed (IDLE/ENTRY only)
//   locked       0 only in OPEN
//   lockout      1 only in LOCKOUT
//   progress     correct digits entered so far in the current attempt (0..4)
//   fail_count   failed attempts since last success/lockout
//   err_pulse    1-cycle pulse on the cycle after a wrong digit is consumed
module locker_ctrl #(
    parameter logic [19:0] CODE           = 20'h33525,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned OPEN_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       relock,
    output logic       ready,
    output logic       locked,
    output logic       lockout,
    output logic [2:0] progress,
    output logic [1:0] fail_count,
    output logic       err_pulse
);

    localparam int unsigned TimerMax =
        (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    // Timer only ever holds load values (max-1), so clog2(max) bits suffice.
    localparam int unsigned TimerW = (TimerMax > 1) ? $clog2(TimerMax) : 1;
    localparam logic [TimerW-1:0] OpenLoad = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]        MaxFails = 3'(MAX_FAILS);

    typedef enum logic [1:0] {StIdle, StEntry, StOpen, StLockout} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              locked_q, locked_d;
    logic              lockout_q, lockout_d;
    logic [2:0]        progress_q, progress_d;
    logic [1:0]        fail_q, fail_d;
    logic              err_q, err_d;

    logic [4:0] shamt;
    logic [3:0] expected;
    logic [2:0] fail_inc;

    // First-entered nibble sits in the top of CODE.
    always_comb begin
        shamt    = 5'd16 - {progress_q, 2'b00};
        expected = 4'(CODE >> shamt);
        fail_inc = {1'b0, fail_q} + 3'd1;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        locked_d   = locked_q;
        lockout_d  = lockout_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle, StEntry: begin
                if (digit_valid) begin
                    if (digit == expected) begin
                        if (progress_q == 3'd4) begin
                            state_d    = StOpen;
                            locked_d   = 1'b0;
                            progress_d = 3'd0;
                            fail_d     = 2'd0;
                            timer_d    = OpenLoad;
                        end else begin
                            state_d    = StEntry;
                            progress_d = progress_q + 3'd1;
                        end
                    end else begin
                        // Wrong digit is discarded, never re-checked as a first digit.
                        state_d    = StIdle;
                        progress_d = 3'd0;
                        err_d      = 1'b1;
                        if (fail_inc == MaxFails) begin
                            state_d   = StLockout;
                            lockout_d = 1'b1;
                            fail_d    = 2'd0;
                            timer_d   = LockLoad;
                        end else begin
                            fail_d = fail_inc[1:0];
                        end
                    end
                end
            end
            StOpen: begin
                if (timer_q == '0 || relock) begin
                    state_d  = StIdle;
                    locked_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d   = StIdle;
                    lockout_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                timer_d    = '0;
                locked_d   = 1'b1;
                lockout_d  = 1'b0;
                progress_d = 3'd0;
                fail_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            locked_q   <= 1'b1;
            lockout_q  <= 1'b0;
            progress_q <= 3'd0;
            fail_q     <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            locked_q   <= locked_d;
            lockout_q  <= lockout_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
        end
    end

    assign ready      = (state_q == StIdle) || (state_q == StEntry);
    assign locked     = locked_q;
    assign lockout    = lockout_q;
    assign progress   = progress_q;
    assign fail_count = fail_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_locker_ctrl.sv
// Self-checking bench for locker_ctrl: a table of {inputs, expected outputs}
// records plus hand-written sequences for lockout, relock and mid-entry reset.
module tb_locker_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       digit_valid;
    logic       relock;
    logic       ready;
    logic       locked;
    logic       lockout;
    logic [2:0] progress;
    logic [1:0] fail_count;
    logic       err_pulse;

    always #5 clk = ~clk;

    locker_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .relock      (relock),
        .ready       (ready),
        .locked      (locked),
        .lockout     (lockout),
        .progress    (progress),
        .fail_count  (fail_count),
        .err_pulse   (err_pulse)
    );

    // exp = {locked, lockout, progress[2:0], fail_count[1:0], err_pulse, ready}
    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] dig;
        logic       dv;
        logic       rl;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] code [5] = '{4'd3, 4'd3, 4'd5, 4'd2, 4'd5};

    function automatic vec_t mk(input string n, input logic r, input logic [3:0] d,
                                input logic dv, input logic rl, input logic l,
                                input logic lo, input logic [2:0] p, input logic [1:0] f,
                                input logic e, input logic rd);
        vec_t v;
        v.name = n;
        v.rst  = r;
        v.dig  = d;
        v.dv   = dv;
        v.rl   = rl;
        v.exp  = {l, lo, p, f, e, rd};
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t       e;
        logic [8:0] act;
        reset       = v.rst;
        digit       = v.dig;
        digit_valid = v.dv;
        relock      = v.rl;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        act = {locked, lockout, progress, fail_count, err_pulse, ready};
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got L=%b LO=%b P=%0d F=%0d E=%b R=%b, expected L=%b LO=%b P=%0d F=%0d E=%b R=%b",
                     e.name, act[8], act[7], act[6:4], act[3:2], act[1], act[0],
                     e.exp[8], e.exp[7], e.exp[6:4], e.exp[3:2], e.exp[1], e.exp[0]);
        end
        digit_valid = 1'b0;
        relock      = 1'b0;
        reset       = 1'b0;
    endtask

    // Enter the full code, one strobe per cycle; fail count f is held until open.
    task automatic push_code(input string n, input logic [1:0] f);
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(n, 0, code[i], 1, 0, 1, 0, 3'(i + 1), f, 0, 1));
        tbl.push_back(mk({n, " open"}, 0, code[4], 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_code(input string n, input logic [1:0] f);
        for (int i = 0; i < 4; i++)
            apply(mk(n, 0, code[i], 1, 0, 1, 0, 3'(i + 1), f, 0, 1));
        apply(mk({n, " open"}, 0, code[4], 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset       = 1'b1;
        digit       = 4'd0;
        digit_valid = 1'b0;
        relock      = 1'b0;
        #1;

        // Test 1: reset, correct code, open for exactly 8 cycles.
        tbl.push_back(mk("t1 reset", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        push_code("t1 code", 2'd0);
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk("t1 open hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t1 timed relock", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        // Test 2: 3,3,7 -> error, then correct code clears the fail count.
        tbl.push_back(mk("t2 d1", 0, 3, 1, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk("t2 d2", 0, 3, 1, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk("t2 wrong", 0, 7, 1, 0, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk("t2 err gone", 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        push_code("t2 code", 2'd1);
        tbl.push_back(mk("t2 relock", 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

        // Test 6: digit held without strobe, relock outside OPEN ignored, back-to-back code.
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk("t6 no strobe", 0, 3, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t6 relock idle", 0, 3, 1, 1, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk("t6 d2", 0, 3, 1, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk("t6 d3", 0, 5, 1, 0, 1, 0, 3, 0, 0, 1));
        tbl.push_back(mk("t6 d4", 0, 2, 1, 0, 1, 0, 4, 0, 0, 1));
        tbl.push_back(mk("t6 open", 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t6 relock", 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // Test 3: three wrong digits -> lockout for exactly 16 cycles, strobes ignored.
        apply(mk("t3 wrong1", 0, 9, 1, 0, 1, 0, 0, 1, 1, 1));
        apply(mk("t3 wrong2", 0, 9, 1, 0, 1, 0, 0, 2, 1, 1));
        apply(mk("t3 lockout", 0, 9, 1, 0, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 15; i++)
            apply(mk("t3 lockout hold", 0, 3, 1, 0, 1, 1, 0, 0, 0, 0));
        apply(mk("t3 lockout end", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        // Test 4: open, strobe in 1st OPEN cycle ignored, relock in 2nd.
        run_code("t4 code", 2'd0);
        apply(mk("t4 strobe in open", 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("t4 relock", 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

        // Test 5: reset mid-entry clears progress and fail count.
        apply(mk("t5 wrong", 0, 7, 1, 0, 1, 0, 0, 1, 1, 1));
        apply(mk("t5 d1", 0, 3, 1, 0, 1, 0, 1, 1, 0, 1));
        apply(mk("t5 d2", 0, 3, 1, 0, 1, 0, 2, 1, 0, 1));
        apply(mk("t5 d3", 0, 5, 1, 0, 1, 0, 3, 1, 0, 1));
        apply(mk("t5 reset", 1, 2, 1, 0, 1, 0, 0, 0, 0, 1));
        run_code("t5 code", 2'd0);
        for (int i = 0; i < 7; i++)
            apply(mk("t5 open hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("t5 timed relock", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        // Reset while OPEN.
        run_code("t5b code", 2'd0);
        apply(mk("t5b reset in open", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
